// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: valid/ready inter-stage buffer built as a circular buffer
// of DEPTH entries. in_ready depends only on registered occupancy, so
// back-pressure never forms a combinational path through this stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (and flush is low). The producer keeps valid and data stable
// until that edge; ready may rise or fall freely and never depends on the
// partner's valid in the same cycle.
module elastic_pipe_reg #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    max_count
);

  // A 1-entry buffer still needs a 1-bit pointer so the vectors stay legal.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_nxt;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    max_nxt;
  logic             push;
  logic             pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // A flush cycle cancels any handshake that would otherwise fire.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // Next pointers, occupancy and high-water mark; flush returns to empty.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = ptr_inc(wr_ptr);
      if (pop)  rd_ptr_nxt = ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
    max_nxt = (count_nxt > max_count) ? count_nxt : max_count;
  end

  // Control state: pointers, occupancy and peak occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      max_count <= '0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      max_count <= max_nxt;
    end
  end

  // Payload storage; cleared by reset so out_data reads zero afterwards,
  // deliberately left intact by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: a DEPTH=2 and a DEPTH=3 instance share clock
// and reset. Vector table for streaming and back-pressure, hand sequences
// for flush and asynchronous reset, then a randomized run on DEPTH=3
// against a queue-based reference model.
module tb_elastic_pipe_reg;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=2 instance signals
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [W-1:0] a_in_data, a_out_data;
  logic [1:0]   a_count, a_max;
  // DEPTH=3 instance signals
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [W-1:0] b_in_data, b_out_data;
  logic [1:0]   b_count, b_max;

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .clk(clk), .reset_n(reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count), .max_count(a_max)
  );

  elastic_pipe_reg #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count), .max_count(b_max)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Compare all observable outputs of one instance against expectations.
  task automatic check_dut(input string tag, input int d, input logic ev, input logic [W-1:0] ed,
                           input logic cd, input int ecnt, input logic eir, input int emax);
    logic ov, ir;
    logic [W-1:0] od;
    logic [1:0] cn, mx;
    if (d == 2) begin ov = a_out_valid; od = a_out_data; cn = a_count; ir = a_in_ready; mx = a_max; end
    else        begin ov = b_out_valid; od = b_out_data; cn = b_count; ir = b_in_ready; mx = b_max; end
    check({tag, ".out_valid"}, 32'(ov), 32'(ev));
    if (cd) check({tag, ".out_data"}, 32'(od), 32'(ed));
    check({tag, ".count"},     32'(cn), 32'(ecnt));
    check({tag, ".in_ready"},  32'(ir), 32'(eir));
    check({tag, ".max_count"}, 32'(mx), 32'(emax));
  endtask

  // ---------------- driver tasks ----------------
  // Drive one instance's inputs, then advance to just after the next edge.
  task automatic step(input int d, input logic iv, input logic [W-1:0] id,
                      input logic ordy, input logic fl);
    if (d == 2) begin a_in_valid = iv; a_in_data = id; a_out_ready = ordy; a_flush = fl; end
    else        begin b_in_valid = iv; b_in_data = id; b_out_ready = ordy; b_flush = fl; end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int           dut;
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         ev;
    logic [W-1:0] ed;
    logic         cd;
    int           ecnt;
    logic         eir;
    int           emax;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input logic iv, input logic [W-1:0] id, input logic ordy,
                              input logic ev, input logic [W-1:0] ed, input logic cd,
                              input int ecnt, input logic eir, input int emax);
    vec_t v;
    v.dut = d; v.iv = iv; v.id = id; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.cd = cd; v.ecnt = ecnt; v.eir = eir; v.emax = emax;
    return v;
  endfunction

  // ---------------- random-run reference model ----------------
  task automatic random_run();
    logic         iv, ordy, acc, pl;
    logic [W-1:0] id;
    int           accepted, mmax;
    iv = 0; id = '0; accepted = 0; mmax = 0;
    exp_q.delete();
    for (int c = 0; c < 60; c++) begin
      // keep an unaccepted word stable, otherwise pick fresh stimulus
      if (!iv) begin
        iv = ($urandom_range(0, 3) != 0);
        id = W'($urandom_range(0, 255));
      end
      ordy = $urandom_range(0, 1) == 1;
      // acceptance rules evaluated on the model's pre-edge occupancy
      acc = iv && (exp_q.size() < 3);
      pl  = ordy && (exp_q.size() > 0);
      step(3, iv, id, ordy, 1'b0);
      if (pl) void'(exp_q.pop_front());
      if (acc) begin exp_q.push_back(id); accepted++; iv = 0; end
      if (exp_q.size() > mmax) mmax = exp_q.size();
      check_dut($sformatf("rnd%0d", c), 3, exp_q.size() != 0,
                (exp_q.size() != 0) ? exp_q[0] : '0, exp_q.size() != 0,
                exp_q.size(), exp_q.size() != 3, mmax);
    end
    check("rnd.accepted_ge_10", 32'(accepted >= 10), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle_inputs();

    // Reset then idle
    do_reset();
    check_dut("rst_d2", 2, 0, '0, 1, 0, 1, 0);
    check_dut("rst_d3", 3, 0, '0, 1, 0, 1, 0);

    // Streaming on DEPTH=2 with out_ready held high
    vecs.push_back(mk(2, 1, 8'h11, 1,  1, 8'h11, 1, 1, 1, 1));
    vecs.push_back(mk(2, 1, 8'h22, 1,  1, 8'h22, 1, 1, 1, 1));
    vecs.push_back(mk(2, 1, 8'h33, 1,  1, 8'h33, 1, 1, 1, 1));
    vecs.push_back(mk(2, 0, 8'h00, 1,  0, 8'h00, 0, 0, 1, 1));
    // Back-pressure on DEPTH=3: fill, stall, then drain in order
    vecs.push_back(mk(3, 1, 8'ha1, 0,  1, 8'ha1, 1, 1, 1, 1));
    vecs.push_back(mk(3, 1, 8'ha2, 0,  1, 8'ha1, 1, 2, 1, 2));
    vecs.push_back(mk(3, 1, 8'ha3, 0,  1, 8'ha1, 1, 3, 0, 3));
    vecs.push_back(mk(3, 1, 8'ha4, 0,  1, 8'ha1, 1, 3, 0, 3));
    vecs.push_back(mk(3, 1, 8'ha4, 0,  1, 8'ha1, 1, 3, 0, 3));
    vecs.push_back(mk(3, 1, 8'ha4, 1,  1, 8'ha2, 1, 2, 1, 3));
    vecs.push_back(mk(3, 1, 8'ha4, 1,  1, 8'ha3, 1, 2, 1, 3));
    vecs.push_back(mk(3, 1, 8'ha5, 1,  1, 8'ha4, 1, 2, 1, 3));
    vecs.push_back(mk(3, 0, 8'h00, 1,  1, 8'ha5, 1, 1, 1, 3));
    vecs.push_back(mk(3, 0, 8'h00, 1,  0, 8'h00, 0, 0, 1, 3));
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].dut, vecs[i].iv, vecs[i].id, vecs[i].ordy, 1'b0);
      check_dut($sformatf("vec%0d", i), vecs[i].dut, vecs[i].ev, vecs[i].ed, vecs[i].cd,
                vecs[i].ecnt, vecs[i].eir, vecs[i].emax);
    end
    idle_inputs();

    // Flush with a simultaneous handshake on DEPTH=2
    do_reset();
    step(2, 1, 8'haa, 0, 0);
    step(2, 1, 8'hbb, 0, 0);
    check_dut("fl_full", 2, 1, 8'haa, 1, 2, 0, 2);
    step(2, 1, 8'hcc, 1, 1);
    check_dut("fl_after", 2, 0, '0, 0, 0, 1, 2);
    step(2, 0, 8'h00, 0, 0);
    check_dut("fl_quiet", 2, 0, '0, 0, 0, 1, 2);
    step(2, 1, 8'hdd, 0, 0);
    check_dut("fl_restart", 2, 1, 8'hdd, 1, 1, 1, 2);
    idle_inputs();

    // Asynchronous reset between edges with two entries held
    do_reset();
    step(3, 1, 8'h5a, 0, 0);
    step(3, 1, 8'ha5, 0, 0);
    step(3, 0, 8'h00, 0, 0);
    check_dut("ar_pre", 3, 1, 8'h5a, 1, 2, 1, 2);
    #3;
    reset_n = 1'b0;
    #1;
    check_dut("ar_now", 3, 0, '0, 1, 0, 1, 0);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_dut("ar_post", 3, 0, '0, 1, 0, 1, 0);

    // Randomized wrap/order run on DEPTH=3
    do_reset();
    random_run();
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised, handshake-based pipeline register that replaces the fixed enable/reset inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with an elastic valid/ready buffer of configurable width and depth. Each instance sits between two pipeline stages and absorbs back-pressure locally, so global stall wiring is not needed. Each instance also supports a synchronous flush for branch redirect and reports live and peak occupancy to the hazard/perf logic.

## Interface
Parameters:
- WIDTH, 32, payload bits per entry. Legal range is 1 or more.
- DEPTH, 2, number of storage entries. Legal range is 1 or more; values that are not a power of two are legal.
- CW, $clog2(DEPTH+1), width of the occupancy outputs. This is derived and must not be overridden.

Ports:
- clk  in  1  single clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous reset, active-low; one clock domain only.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  upstream holds valid payload.
- in_ready  out  1  buffer can accept an entry this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  downstream accepts the head entry.
- out_data  out  WIDTH  head entry payload.
- count  out  CW  current occupancy, from 0 to DEPTH.
- max_count  out  CW  peak occupancy since reset (high-water mark).

## Operation
- Storage is a circular buffer of DEPTH entries, with wr_ptr, rd_ptr and count.
- Both pointers wrap from DEPTH-1 to 0 explicitly; they are not power-of-two masked.
- in_ready = (count != DEPTH). It is purely registered state, with no combinational path from out_ready.
- out_valid = (count != 0).
- out_data = mem[rd_ptr]. It is driven from storage with no bypass of in_data.
- push = in_valid & in_ready & ~flush. On push, mem[wr_ptr] <= in_data and wr_ptr advances.
- pop = out_valid & out_ready & ~flush. On pop, rd_ptr advances.
- count update: +1 on push only; -1 on pop only; unchanged when both or neither occur.
- Simultaneous push and pop at count = DEPTH is impossible, because in_ready = 0.
- Push and pop in the same cycle at 0 < count < DEPTH is legal. count holds and both pointers advance.
- At count = 0 a push may occur, but a pop cannot.
- flush has the highest priority. Next cycle: count = 0, wr_ptr = rd_ptr = 0.
- Any handshake that appears to fire during a flush cycle is discarded.
- Storage contents are not cleared by flush.
- max_count <= max(max_count, next count) every cycle.
- max_count is cleared only by reset_n and is unaffected by flush.
- Upstream protocol: once in_valid is high, in_valid and in_data stay stable until accepted. The block does not check this.
- Ordering is strict FIFO. No entry is duplicated or dropped except by flush.

## Timing
- Reset (reset_n low, asynchronous): count = 0, max_count = 0, pointers = 0, all mem entries = 0.
  - Resulting outputs: out_valid = 0, in_ready = 1, out_data = 0.
- Release of reset_n is synchronised externally; the block needs no recovery cycle.
- Latency: an entry accepted at edge N is presented with out_valid = 1 after edge N. It can be popped at edge N+1 at the earliest.
- Throughput: with DEPTH ≥ 2, one entry per cycle is sustained under continuous out_ready.
- With DEPTH = 1, throughput is one entry every two cycles. This is the intended trade-off for no ready combinational path.
- Reset asserted mid-transfer: all entries are lost immediately, and no partial state survives.
- flush and reset_n low together: reset dominates. The result is identical to reset.

## Test plan
- Reset then idle: hold reset_n = 0, then release. Required: out_valid = 0, in_ready = 1, count = 0, out_data = 0, max_count = 0.
- Streaming, DEPTH = 2, out_ready = 1: push 0x11, 0x22, 0x33 on consecutive cycles.
  - Required: outputs 0x11, 0x22, 0x33 on consecutive cycles, each one cycle after its push.
  - Required: count stays at 1 and in_ready stays 1.
- Full/back-pressure, DEPTH = 3, out_ready = 0: push 5 words.
  - Required: in_ready drops after the 3rd push, count = 3, max_count = 3.
  - Then raise out_ready: the words drain in order, and the 4th word is accepted only after the first pop.
- Non-power-of-two wrap, DEPTH = 3: run 10 push/pop cycles with random out_ready. Required: pointers wrap from 2 to 0 and order is preserved for all 10 words.
- Flush with simultaneous handshake: count = 2 and in_valid = out_ready = 1 in the flush cycle.
  - Required next cycle: count = 0, out_valid = 0, in_ready = 1. The flush-cycle input does not appear at the output, and max_count is unchanged.
- Async reset mid-stream: drop reset_n between clock edges while count = 2. Required: out_valid = 0 and count = 0 immediately, without waiting for a clock edge; max_count = 0.
